spi_byte_engine: RTL and testbench
==================================

Name: spi_byte_engine

Overview:
- SPI mode-0 master byte transceiver for the SD card path.
- Sits directly downstream of the SD command manager. It accepts one byte per `start` strobe, shifts it out on MOSI MSB-first, and captures the byte returned on MISO.
- When the byte completes, it returns the captured byte and a one-cycle `ready` pulse.
- It also owns the SCLK divider (slow init rate vs fast data rate) and the chip-select pin.

Parameters:
- DIV_SLOW, 63, SCLK half-period in clk cycles while fast=0 (card init, ≤400 kHz). Must be ≥3.
- DIV_FAST, 3, SCLK half-period in clk cycles while fast=1. Must be ≥3.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to transfer `in`; honoured only while idle.
- in  in  8  byte to transmit, captured on the cycle `start` is accepted.
- fast  in  1  divider select (1 = DIV_FAST), captured with `start`.
- csz  in  1  1 forces CS deasserted (init dummy clocks); 0 asserts CS.
- out  out  8  byte received in the last completed transfer.
- ready  out  1  one-cycle pulse; `out` is valid on this cycle.
- busy  out  1  high from the cycle after an accepted `start` until the cycle of `ready`, inclusive.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out; idles high.
- miso  in  1  SPI data in; asynchronous to clk.
- cs_n  out  1  card chip select, active-low.

Behaviour:
- Reset values: out=0x00, ready=0, busy=0, sclk=0, mosi=1, cs_n=1, FSM in IDLE, all counters 0. Reset mid-transfer aborts immediately; no `ready` pulse is produced.
- miso passes through a 2-flop synchronizer before use. Its 2-cycle latency is why both DIV values are ≥3.
- cs_n is a registered copy of csz (1 clk latency). It is independent of the FSM, so it may toggle mid-byte.
- FSM states:
  - IDLE: when start=1, latch in→shift register, latch H = fast ? DIV_FAST : DIV_SLOW, bit counter = 7, go to LOW.
  - LOW: sclk=0, mosi=shift[7]. Hold H cycles, then go to HIGH.
  - HIGH: sclk=1. Hold H cycles. On the last HIGH cycle, shift = {shift[6:0], miso_sync}.
    - If bit counter = 0, go to DONE.
    - Otherwise decrement the bit counter and go to LOW; the new MSB appears on mosi as sclk falls.
  - DONE: one cycle. out = captured byte, ready=1, mosi=1, sclk=0, then go to IDLE.
- Latency: `start` at cycle T gives `ready` at cycle T + 16·H + 1. A new `start` may be accepted in the cycle after `ready` (back-to-back bytes are supported).
- `start` while busy (LOW/HIGH/DONE) is ignored: no queueing, and no corruption of the byte in flight.
- in and fast are sampled only at acceptance; later changes have no effect on the current byte.
- Phase counter width: ceil(log2(max(DIV_SLOW, DIV_FAST)+1)). It counts H−1 down to 0 in each phase.
- `out` holds its value until the next DONE; it does not clear on `start`.
- Upstream contract: `start`/`in` are driven combinationally by the manager from registered state. This block adds no input registers beyond the acceptance latch.

Decomposition:
- Shared package sd_spi_pkg holds:
  - FSM state encoding (IDLE, LOW, HIGH, DONE);
  - default divider constants SD_DIV_SLOW=63 and SD_DIV_FAST=3;
  - SD_IDLE_BYTE=8'hFF.
- One natural sub-module: spi_sync2, the 2-flop synchronizer for miso. It is reusable for card-detect.
- Divider, shifter and FSM stay in one module.

Test Plan:
- Reset then idle: rst low for 5 clk, then high → sclk=0, mosi=1, cs_n=1, ready=0, out=0x00. With csz=0, cs_n goes 0 one clk later.
- Loopback (miso tied to mosi), fast=1, start with in=0x40 → exactly 8 sclk rising edges; ready pulses 49 clk after start; out=0x40.
- Slow rate: fast=0, in=0xFF, miso driving 0xA5 MSB-first, changed on sclk falling edges → sclk high/low phases of 63 clk each; out=0xA5 at cycle T+1009.
- Busy rejection: start with 0x51, then pulse start with 0x00 at cycle T+10 → the second request is ignored; only one ready pulse; mosi bit stream is 01010001.
- Back-to-back: start 0x12, then start 0x34 in the cycle after ready → second ready at +49 from the second start; out=0x34 and no sclk glitch between the bytes.
- Mid-transfer reset: assert rst at bit 3 of 0xC3 → next cycle sclk=0, mosi=1, busy=0, cs_n=1; no ready pulse; a fresh start after reset completes normally.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD card SPI path: byte-engine FSM encoding,
// default SCLK dividers and the idle bus byte.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    localparam int SD_DIV_SLOW = 63;
    localparam int SD_DIV_FAST = 3;

    localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit (MISO, card-detect).
module spi_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 master byte transceiver: shifts one byte out MSB-first while capturing
// MISO, with a selectable SCLK divider and a registered chip-select.
module spi_byte_engine
    import sd_spi_pkg::*;
#(
    parameter int DIV_SLOW = SD_DIV_SLOW,
    parameter int DIV_FAST = SD_DIV_FAST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in,
    input  logic       fast,
    input  logic       csz,
    output logic [7:0] out,
    output logic       ready,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int PW      = $clog2(DIV_MAX + 1);

    localparam logic [PW-1:0] H_SLOW = PW'(DIV_SLOW);
    localparam logic [PW-1:0] H_FAST = PW'(DIV_FAST);

    spi_state_t    state, state_n;
    logic [PW-1:0] half, half_n;
    logic [PW-1:0] phase, phase_n;
    logic [2:0]    bits, bits_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    out_n;
    logic          miso_sync;

    spi_sync2 u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d   (miso),
        .q   (miso_sync)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n = state;
        half_n  = half;
        phase_n = phase;
        bits_n  = bits;
        shift_n = shift;
        out_n   = out;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    shift_n = in;
                    half_n  = fast ? H_FAST : H_SLOW;
                    phase_n = half_n - 1'b1;
                    bits_n  = 3'd7;
                    state_n = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase == '0) begin
                    phase_n = half - 1'b1;
                    state_n = ST_HIGH;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase == '0) begin
                    // Sample MISO only at the very end of the high phase so the
                    // synchronizer delay is absorbed inside the half-period.
                    shift_n = {shift[6:0], miso_sync};
                    if (bits == 3'd0) begin
                        out_n   = shift_n;
                        phase_n = '0;
                        state_n = ST_DONE;
                    end else begin
                        bits_n  = bits - 1'b1;
                        phase_n = half - 1'b1;
                        state_n = ST_LOW;
                    end
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Pin-facing outputs are registered from next-state so SCLK/MOSI never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= ST_IDLE;
            half  <= '0;
            phase <= '0;
            bits  <= '0;
            shift <= '0;
            out   <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
            sclk  <= 1'b0;
            mosi  <= 1'b1;
            cs_n  <= 1'b1;
        end else begin
            state <= state_n;
            half  <= half_n;
            phase <= phase_n;
            bits  <= bits_n;
            shift <= shift_n;
            out   <= out_n;
            ready <= (state_n == ST_DONE);
            busy  <= (state_n != ST_IDLE);
            sclk  <= (state_n == ST_HIGH);
            mosi  <= (state_n == ST_LOW || state_n == ST_HIGH) ? shift_n[7] : SD_IDLE_BYTE[7];
            cs_n  <= csz;
        end
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed scoreboard bench for spi_byte_engine: loopback, slow-rate capture,
// busy rejection, back-to-back bytes and mid-transfer reset.
module tb_spi_byte_engine;

    localparam int HF = 3;
    localparam int HS = 63;

    typedef struct packed {
        logic [7:0]  tx;
        logic [7:0]  rx;
        logic [31:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in;
    logic       fast;
    logic       csz;
    logic [7:0] out;
    logic       ready;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rdy_cnt = 0;
    int         rise_cnt = 0;
    int         hi_len = 0;
    int         lo_len = 0;
    int         half_exp = HF;
    logic       had_fall = 1'b0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_bits = 8'h00;
    logic [7:0] miso_pat = 8'h00;
    logic       loop = 1'b1;
    exp_t       sb[$];

    assign miso = loop ? mosi : miso_pat[7];

    spi_byte_engine #(.DIV_SLOW(HS), .DIV_FAST(HF)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in),
        .fast  (fast),
        .csz   (csz),
        .out   (out),
        .ready (ready),
        .busy  (busy),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .cs_n  (cs_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            prev_sclk = 1'b0;
            rise_cnt  = 0;
            hi_len    = 0;
            lo_len    = 0;
            had_fall  = 1'b0;
            mosi_bits = 8'h00;
        end else begin
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                mosi_bits = {mosi_bits[6:0], mosi};
                if (had_fall) check("low_phase_len", lo_len, half_exp);
                hi_len = 1;
            end else if (sclk) begin
                hi_len++;
            end
            if (!sclk && prev_sclk) begin
                check("high_phase_len", hi_len, half_exp);
                had_fall = 1'b1;
                lo_len   = 1;
                miso_pat = {miso_pat[6:0], 1'b0};
            end else if (!sclk) begin
                lo_len++;
            end
            if (ready) begin
                exp_t e;
                rdy_cnt++;
                check("ready_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rx_byte", 32'(out), 32'(e.rx));
                    check("ready_cycle", cyc, e.cyc);
                    check("mosi_stream", 32'(mosi_bits), 32'(e.tx));
                    check("sclk_rises", rise_cnt, 8);
                end
                rise_cnt = 0;
                had_fall = 1'b0;
            end
            prev_sclk = sclk;
        end
    end

    task automatic do_start(input logic [7:0] tx, input logic f, input logic push,
                            input logic [7:0] rx);
        @(negedge clk);
        start = 1'b1;
        in    = tx;
        fast  = f;
        if (push) sb.push_back({tx, rx, 32'(cyc + 16 * (f ? HF : HS) + 1)});
        @(negedge clk);
        start = 1'b0;
        in    = ~tx;
        fast  = ~f;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        rst   = 1'b0;
        start = 1'b0;
        in    = 8'h00;
        fast  = 1'b1;
        csz   = 1'b1;

        // Reset and idle state.
        repeat (5) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd1);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ready), 32'd0);
        check("idle_out", 32'(out), 32'h00);
        check("idle_mosi", 32'(mosi), 32'd1);
        csz = 1'b0;
        #1 check("cs_n_latency", 32'(cs_n), 32'd1);
        @(negedge clk);
        check("cs_n_asserted", 32'(cs_n), 32'd0);

        // Loopback at the fast rate.
        loop = 1'b1;
        half_exp = HF;
        do_start(8'h40, 1'b1, 1'b1, 8'h40);
        wait_idle(200);
        check("ready_count_loop", rdy_cnt, 1);

        // Slow rate, MISO pattern changed on SCLK falling edges.
        loop = 1'b0;
        miso_pat = 8'hA5;
        half_exp = HS;
        do_start(8'hFF, 1'b0, 1'b1, 8'hA5);
        wait_idle(2000);
        check("ready_count_slow", rdy_cnt, 2);

        // Start while busy is ignored.
        loop = 1'b1;
        half_exp = HF;
        do_start(8'h51, 1'b1, 1'b1, 8'h51);
        repeat (9) @(negedge clk);
        start = 1'b1;
        in    = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);
        repeat (80) @(negedge clk);
        check("ready_count_reject", rdy_cnt, 3);
        check("busy_after_reject", 32'(busy), 32'd0);

        // Back-to-back bytes.
        do_start(8'h12, 1'b1, 1'b1, 8'h12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 200);
        check("b2b_first_ready_timeout", 32'(n < 200), 32'd1);
        do_start(8'h34, 1'b1, 1'b1, 8'h34);
        wait_idle(200);
        check("ready_count_b2b", rdy_cnt, 5);
        check("out_holds", 32'(out), 32'h34);

        // Reset in the middle of bit 3.
        do_start(8'hC3, 1'b1, 1'b0, 8'h00);
        n = 0;
        while (rise_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bit3_wait_timeout", 32'(n < 200), 32'd1);
        check("busy_before_reset", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_mosi", 32'(mosi), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("no_ready_after_reset", rdy_cnt, 5);
        check("cs_n_after_reset", 32'(cs_n), 32'd0);
        do_start(8'h3C, 1'b1, 1'b1, 8'h3C);
        wait_idle(200);
        check("ready_count_fresh", rdy_cnt, 6);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
